// File: rtl/calc_core_seq.sv
// Sequential WIDTH-bit arithmetic core: one-cycle add/sub, shift-add multiply and
// restoring divide, with a start/busy/done handshake and chained accumulator mode.
module calc_core_seq #(
  parameter int WIDTH = 8
) (
  input  logic               CLK_28,
  input  logic               RST,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               chain,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               carry,
  output logic               borrow,
  output logic               div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t state_q, state_d;
  op_t    op_q, op_d;

  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   prem_q, prem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               carry_q, carry_d;
  logic               borrow_q, borrow_d;
  logic               div0_q, div0_d;

  logic               last;
  logic [WIDTH-1:0]   opa_sel;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic               ge;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   prem_nxt;
  logic [WIDTH-1:0]   quo_nxt;

  assign last = (cnt_q == CW'(1));

  always_ff @(posedge CLK_28) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  if (last)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prem_d      = prem_q;
    quo_d       = quo_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    carry_d     = carry_q;
    borrow_d    = borrow_q;
    div0_d      = div0_q;

    opa_sel  = chain ? result_q[WIDTH-1:0] : a;
    sum      = {1'b0, opa_q} + {1'b0, opb_q};
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Restoring step: shift the next dividend bit into the partial remainder, keep the subtraction only if it fits
    trial    = {prem_q, quo_q[WIDTH-1]};
    ge       = (trial >= {1'b0, opb_q});
    prem_nxt = ge ? WIDTH'(trial - {1'b0, opb_q}) : trial[WIDTH-1:0];
    quo_nxt  = {quo_q[WIDTH-2:0], ge};

    if (state_q == S_IDLE && start) begin
      op_d     = op_t'(op);
      opa_d    = opa_sel;
      opb_d    = b;
      cnt_d    = (op == 2'b10 || (op == 2'b11 && b != '0)) ? CW'(WIDTH) : CW'(1);
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, opa_sel};
      mplier_d = b;
      prem_d   = '0;
      quo_d    = opa_sel;
    end else if (state_q == S_CALC) begin
      cnt_d    = cnt_q - CW'(1);
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      prem_d   = prem_nxt;
      quo_d    = quo_nxt;
      if (last) begin
        remainder_d = '0;
        carry_d     = 1'b0;
        borrow_d    = 1'b0;
        div0_d      = 1'b0;
        case (op_q)
          OP_ADD: begin
            result_d = {{(WIDTH-1){1'b0}}, sum};
            carry_d  = sum[WIDTH];
          end
          OP_SUB: begin
            result_d = {{WIDTH{1'b0}}, opa_q - opb_q};
            borrow_d = (opa_q < opb_q);
          end
          OP_MUL: result_d = acc_nxt;
          OP_DIV: begin
            if (opb_q == '0) begin
              result_d    = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
              remainder_d = opa_q;
              div0_d      = 1'b1;
            end else begin
              result_d    = {{WIDTH{1'b0}}, quo_nxt};
              remainder_d = prem_nxt;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK_28) begin
    if (RST) begin
      op_q        <= OP_ADD;
      opa_q       <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
      div0_q      <= 1'b0;
    end else begin
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prem_q      <= prem_d;
      quo_q       <= quo_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
      div0_q      <= div0_d;
    end
  end

  assign result    = result_q;
  assign remainder = remainder_q;
  assign carry     = carry_q;
  assign borrow    = borrow_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_calc_core_seq.sv
// Directed bench for calc_core_seq at WIDTH=8 with hand-computed expected values.
module tb_calc_core_seq;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         chain = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic [2*W-1:0] result;
  logic [W-1:0] remainder;
  logic         busy, done, carry, borrow, div0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  calc_core_seq #(.WIDTH(W)) dut (
    .CLK_28    (clk),
    .RST       (rst),
    .start     (start),
    .op        (op),
    .chain     (chain),
    .a         (a),
    .b         (b),
    .result    (result),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .carry     (carry),
    .borrow    (borrow),
    .div0      (div0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [15:0] r, input logic [7:0] rm,
                           input logic c, input logic bo, input logic d0);
    check({tag, ".result"}, 32'(result), 32'(r));
    check({tag, ".rem"}, 32'(remainder), 32'(rm));
    check({tag, ".carry"}, 32'(carry), 32'(c));
    check({tag, ".borrow"}, 32'(borrow), 32'(bo));
    check({tag, ".div0"}, 32'(div0), 32'(d0));
  endtask

  // Issues one operation, optionally pulses start again 'ign' edges after capture,
  // scrambles the operand inputs after capture, and checks latency/busy/done shape.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] aa,
                       input logic [7:0] bb, input logic ch, input int n, input int ign);
    int seen, busyc, extra;
    seen = -1; busyc = 0; extra = 0;
    @(negedge clk);
    op = o; a = aa; b = bb; chain = ch; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = (ign > 0 && i == ign - 1);
      a = ~aa; b = ~bb; chain = ~ch; op = ~o;
      if (busy) busyc++;
      if (done) begin
        seen = i;
        break;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, 32'(seen), 32'(n));
    check({tag, ".busycycles"}, 32'(busyc), 32'(n + 1));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) check({tag, ".busy_after"}, 32'(busy), 32'd0);
      if (done) extra++;
    end
    check({tag, ".extra_done"}, 32'(extra), 32'd0);
  endtask

  logic [1:0]  bo_op [3] = '{2'b01, 2'b00, 2'b01};
  logic [7:0]  bo_a  [3] = '{8'd3, 8'd200, 8'd9};
  logic [7:0]  bo_b  [3] = '{8'd5, 8'd56, 8'd4};
  logic [15:0] bo_r  [3] = '{16'h00FE, 16'h0100, 16'h0005};
  logic        bo_c  [3] = '{1'b0, 1'b1, 1'b0};
  logic        bo_bw [3] = '{1'b1, 1'b0, 1'b0};

  initial begin
    int extra, idx, last_t;

    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check_out("reset", 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    do_op("add", 2'b00, 8'd200, 8'd100, 1'b0, 1, 0);
    check_out("add", 16'h012C, 8'd0, 1'b1, 1'b0, 1'b0);

    do_op("sub", 2'b01, 8'd5, 8'd9, 1'b0, 1, 0);
    check_out("sub", 16'h00FC, 8'd0, 1'b0, 1'b1, 1'b0);

    do_op("chain", 2'b00, 8'h33, 8'd4, 1'b1, 1, 0);
    check_out("chain", 16'h0100, 8'd0, 1'b1, 1'b0, 1'b0);

    do_op("mul", 2'b10, 8'd255, 8'd255, 1'b0, 8, 3);
    check_out("mul", 16'hFE01, 8'd0, 1'b0, 1'b0, 1'b0);

    do_op("div", 2'b11, 8'd200, 8'd7, 1'b0, 8, 0);
    check_out("div", 16'h001C, 8'd4, 1'b0, 1'b0, 1'b0);

    do_op("div0", 2'b11, 8'd77, 8'd0, 1'b0, 1, 0);
    check_out("div0", 16'h00FF, 8'd77, 1'b0, 1'b0, 1'b1);

    do_op("mul2", 2'b10, 8'd13, 8'd11, 1'b0, 8, 0);
    check_out("mul2", 16'h008F, 8'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a multiply
    @(negedge clk);
    op = 2'b10; a = 8'd250; b = 8'd3; chain = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 3) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.done", 32'(done), 32'd0);
    check_out("rstmid", 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("rstmid.no_done", 32'(extra), 32'd0);

    do_op("add11", 2'b00, 8'd1, 8'd1, 1'b0, 1, 0);
    check_out("add11", 16'h0002, 8'd0, 1'b0, 1'b0, 1'b0);

    // Reset and start together: reset must win
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 8'd5; b = 8'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start.busy", 32'(busy), 32'd0);
    check("rst_start.result", 32'(result), 32'd0);

    // Start held high: one op per N+2 cycles, flags replaced at each done
    @(negedge clk);
    op = bo_op[0]; a = bo_a[0]; b = bo_b[0]; chain = 1'b0; start = 1'b1;
    idx = 0; last_t = -1;
    for (int t = 1; t <= 40 && idx < 3; t++) begin
      @(negedge clk);
      if (done) begin
        check($sformatf("b2b%0d.result", idx), 32'(result), 32'(bo_r[idx]));
        check($sformatf("b2b%0d.carry", idx), 32'(carry), 32'(bo_c[idx]));
        check($sformatf("b2b%0d.borrow", idx), 32'(borrow), 32'(bo_bw[idx]));
        if (idx == 0) check("b2b.first_t", 32'(t), 32'd2);
        else          check($sformatf("b2b%0d.gap", idx), 32'(t - last_t), 32'd3);
        last_t = t;
        idx++;
        if (idx < 3) begin
          op = bo_op[idx]; a = bo_a[idx]; b = bo_b[idx];
        end
      end
    end
    start = 1'b0;
    check("b2b.count", 32'(idx), 32'd3);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_core_seq.md
Name: calc_core_seq

Overview:
Parametrised sequential arithmetic core for the board calculator. It replaces the fixed 4-bit combinational result path with a WIDTH-bit engine. Add and subtract complete in one cycle; multiply (shift-add) and divide (restoring) are multi-cycle. It adds a start/busy/done handshake, a chained accumulator mode, and carry, borrow and divide-by-zero flags. It sits between the debounced key/switch front end and the 7-segment display driver.

Parameters:
WIDTH, 8, operand width in bits (legal 2..16).

Ports:
CLK_28  input  1  system clock; all state changes on its rising edge
RST  input  1  synchronous, active-high reset
start  input  1  single-cycle request pulse (edge-detected key, supplied externally)
op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div
chain  input  1  1 = use low WIDTH bits of the current result as operand A instead of a
a  input  WIDTH  operand A (unsigned)
b  input  WIDTH  operand B (unsigned)
result  output  2*WIDTH  registered result
remainder  output  WIDTH  registered division remainder
busy  output  1  high whenever the FSM is not in IDLE
done  output  1  one-cycle pulse: result and flags have just updated
carry  output  1  add carry-out
borrow  output  1  sub borrow (A < B)
div0  output  1  divide by zero occurred

Behaviour:
- Reset (RST=1 at an edge): state=IDLE; result, remainder, busy, done, carry, borrow, div0 all 0; internal counters and shift registers 0. Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE: on start=1 at edge k, capture opA (a, or result[WIDTH-1:0] if chain=1), opB=b and op. Load iteration count N (add/sub N=1; mul/div N=WIDTH; div with b=0 N=1). Go to CALC.
- start while busy=1 (CALC or DONE) is ignored and is not queued.
- CALC: perform one iteration per cycle for N cycles. At edge k+N, write result, remainder and flags, then go to DONE.
- DONE: done=1 for exactly this one cycle; go to IDLE at the next edge. busy=0 again at the cycle after DONE.
- Latency: done is high in the cycle following edge k+N; the next start is accepted at edge k+N+2 at the earliest.
- add: result = zero-extended WIDTH+1-bit sum. carry = sum bit WIDTH. borrow=0, div0=0.
- sub: result = zero-extended (opA-opB) mod 2^WIDTH. borrow = (opA<opB). carry=0, div0=0.
- mul: unsigned shift-add, LSB of multiplier first, over WIDTH cycles. result = full 2*WIDTH product. All flags 0.
- div: restoring division, one quotient bit per cycle, MSB first, over WIDTH cycles. result = zero-extended quotient; remainder = remainder. Flags 0.
- div with opB=0: no iteration. result = {WIDTH zeros, WIDTH ones}, remainder = opA, div0=1.
- remainder is updated only by div; it is cleared to 0 at done of the other ops.
- result, remainder and flags hold their values between done pulses. Operand inputs may change freely after the capture edge without effect.
- Simultaneous RST and start: RST wins.
- chain with an operation in flight: operand A is taken from the result value present at the capture edge.

Test Plan (WIDTH=8):
1. Add: a=200, b=100, op=00, start at edge k -> done in the cycle after edge k+1; result=0x012C, carry=1, borrow=0.
2. Sub with borrow: a=5, b=9, op=01 -> result=0x00FC, borrow=1, carry=0. Then chain=1, b=4, op=00 -> result=0x0100, carry=1.
3. Mul: a=255, b=255, op=10 -> busy high for 9 cycles; done after edge k+8; result=0xFE01. A start pulse at k+3 is ignored (exactly one done pulse).
4. Div: a=200, b=7, op=11 -> done after edge k+8; result=0x001C, remainder=4. Div by zero: a=77, b=0 -> done after edge k+1; result=0x00FF, remainder=77, div0=1.
5. Reset mid-mul: start a mul, assert RST at edge k+4 -> no done pulse; all outputs 0 at the next cycle. A fresh add a=1, b=1 then gives result=2.
6. Back-to-back: a start held high continuously -> one operation per N+2 cycles. Results and done pulses are correct; flags from the previous op are replaced at each done.
